// File: rtl/mem_stage_access.sv
// Memory-stage load/store sequencer: aligns, masks and lane-replicates requests, extends load data.
// Latency: accept N, mem_req N+1, done one cycle after ack or timeout; busy stalls the pipe while REQ.
module mem_stage_access #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_in,
   input  logic [1:0]          op,
   input  logic [1:0]          size,
   input  logic                sign_ext,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata,
   output logic                done,
   output logic                busy,
   output logic                misalign,
   output logic                timeout,
   output logic                mem_req,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_din,
   output logic [DATA_W/8-1:0] mem_mask,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_dout
);

   localparam int NB = DATA_W / 8;
   localparam int LB = $clog2(NB);
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
   localparam logic [1:0] OP_LD = 2'd1;
   localparam logic [1:0] OP_ST = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          op_q, op_d;
   logic [1:0]          size_q, size_d;
   logic                sext_q, sext_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                to_q, to_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                is_ls;
   logic                lsb_bad;
   logic                accept;
   logic [LB-1:0]       lane;
   logic [DATA_W-1:0]   shifted;
   logic [DATA_W-1:0]   keep;
   logic                sbit;
   logic [DATA_W-1:0]   ld_data;
   logic [NB-1:0]       base_mask;

   // Alignment: an access of 2^size bytes must sit on a 2^size boundary.
   always_comb begin
      lsb_bad = 1'b0;
      case (size)
         2'd0:    lsb_bad = 1'b0;
         2'd1:    lsb_bad = addr[0];
         2'd2:    lsb_bad = |addr[1:0];
         default: lsb_bad = (DATA_W == 32) ? 1'b1 : (|addr[2:0]);
      endcase
   end

   assign is_ls    = (op == OP_LD) || (op == OP_ST);
   assign misalign = valid_in && is_ls && lsb_bad;
   assign accept   = valid_in && is_ls && !lsb_bad &&
                     ((state_q == S_IDLE) || (state_q == S_DONE));

   assign lane    = addr_q[LB-1:0];
   assign shifted = mem_dout >> {lane, 3'b000};

   always_comb begin
      keep = '0;
      sbit = 1'b0;
      case (size_q)
         2'd0:    begin keep[7:0]  = '1; sbit = shifted[7];        end
         2'd1:    begin keep[15:0] = '1; sbit = shifted[15];       end
         2'd2:    begin keep[31:0] = '1; sbit = shifted[31];       end
         default: begin keep       = '1; sbit = shifted[DATA_W-1]; end
      endcase
      ld_data = (shifted & keep) | (~keep & {DATA_W{sext_q & sbit}});
   end

   always_comb begin
      base_mask = '0;
      mem_din   = wdata_q;
      case (size_q)
         2'd0:    begin base_mask[0]   = 1'b1; mem_din = {NB{wdata_q[7:0]}};       end
         2'd1:    begin base_mask[1:0] = '1;   mem_din = {(NB/2){wdata_q[15:0]}};  end
         2'd2:    begin base_mask[3:0] = '1;   mem_din = {(NB/4){wdata_q[31:0]}};  end
         default: begin base_mask      = '1;   mem_din = wdata_q;                  end
      endcase
   end

   assign mem_req   = (state_q == S_REQ);
   assign mem_write = (state_q == S_REQ) && (op_q == OP_ST);
   assign mem_mask  = mem_write ? (base_mask << lane) : '0;
   assign mem_addr  = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
   assign busy      = (state_q == S_REQ) || accept;
   assign done      = (state_q == S_DONE);
   assign timeout   = (state_q == S_DONE) && to_q;
   assign rdata     = rdata_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      size_d  = size_q;
      sext_d  = sext_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      rdata_d = '0;
      case (state_q)
         S_IDLE: if (accept) state_d = S_REQ;
         S_REQ: begin
            // Ack wins over timeout when both land in the last permitted cycle.
            if (mem_ack) begin
               state_d = S_DONE;
               to_d    = 1'b0;
               rdata_d = (op_q == OP_LD) ? ld_data : '0;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = S_DONE;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = accept ? S_REQ : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         op_d    = op;
         size_d  = size;
         sext_d  = sign_ext;
         addr_d  = addr;
         wdata_d = wdata;
         cnt_d   = '0;
         to_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         size_q  <= '0;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: doc/mem_stage_access.md
MEM_STAGE_ACCESS -- requirements
Module: mem_stage_access

Interface
REQ-001 Parameter DATA_W, default 32, data-path width in bits; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter MAX_WAIT, default 15, maximum request cycles without ack before timeout, 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 resets all state immediately.
REQ-006 valid_in  in  1  request present this cycle.
REQ-007 op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none).
REQ-008 size  in  2  0 byte, 1 half, 2 word (32b), 3 dword (64b).
REQ-009 sign_ext  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-010 addr  in  ADDR_W  byte address of access.
REQ-011 wdata  in  DATA_W  store data, right-aligned.
REQ-012 rdata  out  DATA_W  load result, valid while done=1.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 busy  out  1  stall request to the pipeline.
REQ-015 misalign  out  1  combinational illegal-request flag.
REQ-016 timeout  out  1  completion was by timeout; qualifies done.
REQ-017 mem_req / mem_write  out  1 / 1  memory request and direction (1 = write).
REQ-018 mem_addr  out  ADDR_W  addr with low log2(DATA_W/8) bits forced to 0.
REQ-019 mem_din / mem_mask  out  DATA_W / DATA_W/8  lane-replicated write data and byte-enable mask.
REQ-020 mem_ack / mem_dout  in  1 / DATA_W  memory completion strobe and read data, sampled when mem_ack=1.

Function
REQ-021 FSM states IDLE, REQ, DONE; request accepted only in IDLE or DONE when valid_in=1, op in {1,2}, misalign=0.
REQ-022 misalign=1 when addr not a multiple of 2^size bytes, or size=3 with DATA_W=32; such a request is dropped: no state change, busy=0, no memory access.
REQ-023 Acceptance registers op, size, sign_ext, lane = addr low bits, addr, wdata; next state REQ.
REQ-024 In REQ: mem_req=1, mem_addr/mem_write/mem_din/mem_mask driven from registered fields and held stable until ack or timeout.
REQ-025 mem_mask = (2^(2^size))-1 shifted left by lane; mem_din = wdata low 2^size bytes replicated across all lanes; mem_mask=0 for loads.
REQ-026 mem_ack=1 in a REQ cycle ends the access: load data = mem_dout shifted right by lane*8, truncated to 2^size bytes, extended per sign_ext to DATA_W; next state DONE.
REQ-027 Wait counter cleared on acceptance, incremented each REQ cycle with mem_ack=0; on reaching MAX_WAIT, next state DONE with timeout latched, rdata=0.
REQ-028 DONE lasts exactly one cycle: done=1, rdata valid (0 for stores), timeout as latched; next state IDLE unless a new request is accepted, then REQ.
REQ-029 busy = (state==REQ) OR (acceptance this cycle); busy=0 in DONE unless a new request is accepted that cycle.
REQ-030 Minimum latency: acceptance at cycle N, mem_req at N+1, ack at N+1 gives done at N+2.
REQ-031 mem_ack outside REQ is ignored; valid_in while in REQ is ignored (pipeline is stalled by busy).

Reset
REQ-032 On reset=0: state IDLE, counter 0, all registered fields 0; mem_req, mem_write, done, busy, timeout = 0; rdata, mem_din, mem_mask, mem_addr = 0.
REQ-033 Reset mid-access drops mem_req asynchronously; no done pulse is produced for the aborted access.

Verification
REQ-034 Load byte signed, addr=0x1003, mem_dout=0x80xxxxxx, ack immediate -> mem_addr=0x1000, done at N+2, rdata=0xFFFFFF80.
REQ-035 Store half, addr=0x2002, wdata=0x1234 -> mem_mask=4'b1100, mem_din=0x12341234, mem_write=1, busy high N..N+1.
REQ-036 Load word addr=0x3001 -> misalign=1, mem_req stays 0, busy=0, no done.
REQ-037 MAX_WAIT=3, ack never asserted -> mem_req high 3 cycles, then done=1 and timeout=1, rdata=0.
REQ-038 Back-to-back: new load presented in DONE cycle -> accepted, mem_req in next cycle, no idle gap.
REQ-039 reset=0 during REQ with wait count 2 -> mem_req and busy 0 immediately; after release, state IDLE, no done.
